// File: rtl/teclado_urna.sv
// teclado_urna: 4x4 active-low matrix keypad front end for the ballot box.
// Scans one row at a time, debounces presses and releases, and turns each
// physical press into exactly one registered strobe (valid, valid+confirma,
// or corrige).
// Optional build macro TECLADO_BEEP_EN adds a 'beep' output that chirps on
// every accepted key.
module teclado_urna #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3,
  parameter int PULSE_CYCLES = 2
`ifdef TECLADO_BEEP_EN
  ,
  parameter int BEEP_HALF    = 8
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] digit,
  output logic       valid,
  output logic       confirma,
  output logic       corrige
`ifdef TECLADO_BEEP_EN
  ,
  output logic       beep
`endif
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int PUL_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_EMIT     = 2'd2;
  localparam logic [1:0] ST_WAIT_REL = 2'd3;

  logic [3:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       state_q, state_d;
  logic [1:0]       key_col_q, key_col_d;
  logic [CNT_W-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] rel_q, rel_d;
  logic [PUL_W-1:0] pulse_q, pulse_d;
  logic [3:0]       digit_q, digit_d;
  logic             valid_q, valid_d;
  logic             confirma_q, confirma_d;
  logic             corrige_q, corrige_d;

  logic       tick;
  logic [3:0] sample;
  logic       hit;
  logic [1:0] hit_col;
  logic [3:0] key_pat;
  logic       key_is_corr;
  logic       key_is_conf;
  logic [3:0] key_code;

  assign tick    = (div_q == DIV_W'(SCAN_DIV - 1));
  assign sample  = sync2_q;
  assign row     = ~(4'b0001 << idx_q);
  assign key_pat = ~(4'b0001 << key_col_q);

  // The row index stays frozen while a key is latched, so it doubles as the key row
  assign key_is_corr = (idx_q == 2'd3) && (key_col_q == 2'd0);
  assign key_is_conf = (idx_q == 2'd3) && (key_col_q == 2'd2);
  assign key_code    = (idx_q == 2'd3) ? 4'd0
                     : ({2'b00, idx_q} * 4'd3) + {2'b00, key_col_q} + 4'd1;

  assign digit    = digit_q;
  assign valid    = valid_q;
  assign confirma = confirma_q;
  assign corrige  = corrige_q;

  // Accept only a single pressed column; column 3 (A-D) counts as no key
  always_comb begin
    hit     = 1'b1;
    hit_col = 2'd0;
    case (sample)
      4'b1110: hit_col = 2'd0;
      4'b1101: hit_col = 2'd1;
      4'b1011: hit_col = 2'd2;
      default: hit     = 1'b0;
    endcase
  end

  // Scan / debounce / emit / wait-for-release sequencing and strobe generation
  always_comb begin
    sync1_d    = col;
    sync2_d    = sync1_q;
    div_d      = tick ? '0 : div_q + DIV_W'(1);
    idx_d      = idx_q;
    state_d    = state_q;
    key_col_d  = key_col_q;
    deb_d      = deb_q;
    rel_d      = rel_q;
    pulse_d    = pulse_q;
    digit_d    = digit_q;
    valid_d    = valid_q;
    confirma_d = confirma_q;
    corrige_d  = corrige_q;
    case (state_q)
      ST_SCAN: begin
        if (tick) begin
          if (hit) begin
            key_col_d = hit_col;
            deb_d     = CNT_W'(1);
            state_d   = ST_DEBOUNCE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (deb_q == CNT_W'(DEBOUNCE_CNT)) begin
          state_d = ST_EMIT;
          pulse_d = '0;
          if (key_is_corr) begin
            corrige_d = 1'b1;
          end else if (key_is_conf) begin
            valid_d    = 1'b1;
            confirma_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            digit_d = key_code;
          end
        end else if (tick) begin
          if (sample == key_pat) begin
            deb_d = deb_q + CNT_W'(1);
          end else begin
            state_d = ST_SCAN;
            idx_d   = idx_q + 2'd1;
          end
        end
      end
      ST_EMIT: begin
        if (pulse_q == PUL_W'(PULSE_CYCLES - 1)) begin
          state_d    = ST_WAIT_REL;
          pulse_d    = '0;
          rel_d      = '0;
          valid_d    = 1'b0;
          confirma_d = 1'b0;
          corrige_d  = 1'b0;
        end else begin
          pulse_d = pulse_q + PUL_W'(1);
        end
      end
      default: begin
        if (rel_q == CNT_W'(DEBOUNCE_CNT)) begin
          state_d = ST_SCAN;
          idx_d   = idx_q + 2'd1;
        end else if (tick) begin
          rel_d = (sample == 4'hF) ? rel_q + CNT_W'(1) : '0;
        end
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q    <= 4'hF;
      sync2_q    <= 4'hF;
      div_q      <= '0;
      idx_q      <= 2'd0;
      state_q    <= ST_SCAN;
      key_col_q  <= 2'd0;
      deb_q      <= '0;
      rel_q      <= '0;
      pulse_q    <= '0;
      digit_q    <= 4'd0;
      valid_q    <= 1'b0;
      confirma_q <= 1'b0;
      corrige_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
      key_col_q  <= key_col_d;
      deb_q      <= deb_d;
      rel_q      <= rel_d;
      pulse_q    <= pulse_d;
      digit_q    <= digit_d;
      valid_q    <= valid_d;
      confirma_q <= confirma_d;
      corrige_q  <= corrige_d;
    end
  end

`ifdef TECLADO_BEEP_EN
  localparam int BEEP_LEN = 16 * BEEP_HALF;
  localparam int BL_W     = $clog2(BEEP_LEN + 1);
  localparam int BH_W     = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

  logic            emit_start;
  logic            beep_q, beep_d;
  logic [BL_W-1:0] left_q, left_d;
  logic [BH_W-1:0] half_q, half_d;

  assign emit_start = (state_q == ST_DEBOUNCE) && (deb_q == CNT_W'(DEBOUNCE_CNT));
  assign beep       = beep_q;

  // Square-wave chirp that (re)starts on every accepted key, then falls silent
  always_comb begin
    beep_d = beep_q;
    left_d = left_q;
    half_d = half_q;
    if (emit_start) begin
      beep_d = 1'b1;
      left_d = BL_W'(BEEP_LEN - 1);
      half_d = '0;
    end else if (left_q != '0) begin
      left_d = left_q - BL_W'(1);
      if (half_q == BH_W'(BEEP_HALF - 1)) begin
        half_d = '0;
        beep_d = ~beep_q;
      end else begin
        half_d = half_q + BH_W'(1);
      end
    end else begin
      beep_d = 1'b0;
    end
  end

  // Beep registers, silenced by reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      beep_q <= 1'b0;
      left_q <= '0;
      half_q <= '0;
    end else begin
      beep_q <= beep_d;
      left_q <= left_d;
      half_q <= half_d;
    end
  end
`endif

endmodule

// File: tb/tb_teclado_urna.sv
// Directed testbench for teclado_urna with a behavioural keypad matrix model.
module tb_teclado_urna;

  logic       clock;
  logic       reset;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] digit;
  logic       valid;
  logic       confirma;
  logic       corrige;
`ifdef TECLADO_BEEP_EN
  logic       beep;
`endif

  logic [1:0] press_row;
  logic [3:0] press_cols;

  int vec_count        = 0;
  int miscompare_count = 0;

  int   valid_rises = 0;
  int   valid_high  = 0;
  int   conf_rises  = 0;
  int   corr_rises  = 0;
  int   excl_viol   = 0;
  logic valid_prev  = 1'b0;
  logic conf_prev   = 1'b0;
  logic corr_prev   = 1'b0;

  teclado_urna dut (
    .clock    (clock),
    .reset    (reset),
    .col      (col),
    .row      (row),
    .digit    (digit),
    .valid    (valid),
    .confirma (confirma),
    .corrige  (corrige)
`ifdef TECLADO_BEEP_EN
    ,
    .beep     (beep)
`endif
  );

  // 100 MHz-style free-running clock
  always #5 clock = ~clock;

  // Keypad matrix: pressed columns pull low only while their row is driven
  always_comb begin
    col = 4'hF;
    if (row == ~(4'b0001 << press_row)) col = ~press_cols;
  end

  // Strobe monitor: counts pulses and flags illegal strobe combinations
  always @(negedge clock) begin
    valid_prev <= valid;
    conf_prev  <= confirma;
    corr_prev  <= corrige;
    if (valid && !valid_prev)    valid_rises <= valid_rises + 1;
    if (valid)                   valid_high  <= valid_high + 1;
    if (confirma && !conf_prev)  conf_rises  <= conf_rises + 1;
    if (corrige && !corr_prev)   corr_rises  <= corr_rises + 1;
    if ((valid && corrige) || (confirma && !valid)) excl_viol <= excl_viol + 1;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vec_count++;
    if (observed != expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [3:0] cols);
    press_row  = r;
    press_cols = cols;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Returns on the first falling edge after the scan moves onto 'target'
  task automatic wait_row(input logic [3:0] target);
    logic [3:0] prev;
    bit         found;
    found = 1'b0;
    prev  = row;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clock);
      if (row == target && prev != target) found = 1'b1;
      prev = row;
    end
    checkOutput("row_reach", int'(found), 1);
  endtask

  // Waits for row r to be scanned, then presses the given columns on it
  task automatic key_at_row(input logic [1:0] r, input logic [3:0] cols);
    wait_row(~(4'b0001 << r));
    applyStimulus(r, cols);
  endtask

  task automatic release_and_settle();
    applyStimulus(2'd0, 4'b0000);
    wait_neg(24);
  endtask

  logic [3:0] exp_rows [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  int v0, h0, c0, k0;

  initial begin
    clock = 1'b0;
    reset = 1'b0;
    applyStimulus(2'd0, 4'b0000);

    // Reset held for two clocks
    wait_neg(2);
    checkOutput("rst_row", int'(row), 'b1110);
    checkOutput("rst_digit", int'(digit), 0);
    checkOutput("rst_valid", int'(valid), 0);
    checkOutput("rst_confirma", int'(confirma), 0);
    checkOutput("rst_corrige", int'(corrige), 0);
    reset = 1'b1;
    wait_neg(1);
    checkOutput("scan_row0", int'(row), 'b1110);
    for (int k = 0; k < 4; k++) begin
      wait_neg(4);
      checkOutput("scan_row", int'(row), int'(exp_rows[k]));
      checkOutput("scan_quiet", int'(valid | corrige), 0);
    end

    // Key 5 held for 60 clocks: one 2-clock valid pulse, no repeat
    v0 = valid_rises; h0 = valid_high;
    key_at_row(2'd1, 4'b0010);
    wait_neg(12);
    checkOutput("k5_early", int'(valid), 0);
    wait_neg(1);
    checkOutput("k5_valid", int'(valid), 1);
    checkOutput("k5_digit", int'(digit), 5);
    checkOutput("k5_confirma", int'(confirma), 0);
    wait_neg(1);
    checkOutput("k5_valid2", int'(valid), 1);
    wait_neg(1);
    checkOutput("k5_drop", int'(valid), 0);
    wait_neg(45);
    release_and_settle();
    checkOutput("k5_pulses", valid_rises - v0, 1);
    checkOutput("k5_width", valid_high - h0, 2);

    // Confirm key: valid+confirma, digit keeps 5
    c0 = conf_rises;
    key_at_row(2'd3, 4'b0100);
    wait_neg(12);
    checkOutput("hash_early", int'(valid), 0);
    wait_neg(1);
    checkOutput("hash_valid", int'(valid), 1);
    checkOutput("hash_confirma", int'(confirma), 1);
    checkOutput("hash_digit", int'(digit), 5);
    wait_neg(1);
    checkOutput("hash_confirma2", int'(confirma), 1);
    wait_neg(1);
    checkOutput("hash_drop", int'(valid | confirma), 0);
    wait_neg(25);
    release_and_settle();
    checkOutput("hash_pulses", conf_rises - c0, 1);

    // Key 7 bounces after two good samples, then presses cleanly
    v0 = valid_rises;
    key_at_row(2'd2, 4'b0001);
    wait_neg(8);
    applyStimulus(2'd2, 4'b0000);
    wait_neg(2);
    checkOutput("k7_frozen", int'(row), 'b1011);
    wait_neg(2);
    checkOutput("k7_rescan", int'(row), 'b0111);
    checkOutput("k7_bounce_quiet", valid_rises - v0, 0);
    applyStimulus(2'd2, 4'b0001);
    wait_neg(24);
    checkOutput("k7_early", int'(valid), 0);
    wait_neg(1);
    checkOutput("k7_valid", int'(valid), 1);
    checkOutput("k7_digit", int'(digit), 7);
    wait_neg(30);
    release_and_settle();
    checkOutput("k7_pulses", valid_rises - v0, 1);

    // Keys 1 and 2 together: ambiguous, nothing emitted
    v0 = valid_rises; k0 = corr_rises;
    applyStimulus(2'd0, 4'b0011);
    wait_neg(40);
    release_and_settle();
    checkOutput("multi_valid", valid_rises - v0, 0);
    checkOutput("multi_corrige", corr_rises - k0, 0);
    checkOutput("multi_digit", int'(digit), 7);

    // Correction key: corrige only
    key_at_row(2'd3, 4'b0001);
    wait_neg(13);
    checkOutput("star_corrige", int'(corrige), 1);
    checkOutput("star_valid", int'(valid), 0);
    wait_neg(2);
    checkOutput("star_drop", int'(corrige), 0);
    checkOutput("star_digit", int'(digit), 7);
    release_and_settle();
    checkOutput("star_pulses", corr_rises - k0, 1);

    // Reset in the middle of the pulse for key 9
    key_at_row(2'd2, 4'b0100);
    wait_neg(13);
    checkOutput("k9_valid", int'(valid), 1);
    checkOutput("k9_digit", int'(digit), 9);
    reset = 1'b0;
    wait_neg(1);
    checkOutput("k9_rst_valid", int'(valid), 0);
    checkOutput("k9_rst_digit", int'(digit), 0);
    checkOutput("k9_rst_row", int'(row), 'b1110);
    checkOutput("k9_rst_strobes", int'(confirma | corrige), 0);
`ifdef TECLADO_BEEP_EN
    checkOutput("k9_rst_beep", int'(beep), 0);
`endif
    applyStimulus(2'd0, 4'b0000);
    reset = 1'b1;
    wait_neg(4);
    checkOutput("post_rst_row", int'(row), 'b1101);

    wait_neg(2);
    checkOutput("strobe_exclusive", excl_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
    $finish;
  end

endmodule

// File: doc/teclado_urna.md
Name: teclado_urna

Overview:
- Matrix-keypad front end that produces the `digit`/`valid`/`confirma` strobes the ballot-box FSM consumes.
- Scans a 4x4 active-low keypad one row at a time, debounces each press and encodes it.
- Emits exactly one strobe per physical press. A correction key produces a separate pulse.
- Sits between the board keypad pins and the vote-capture block.

Parameters:
- SCAN_DIV, 4: clocks each row is driven before its columns are sampled; must be >= 3.
- DEBOUNCE_CNT, 3: consecutive identical samples required to accept a press or a release.
- PULSE_CYCLES, 2: clocks that `valid`/`confirma`/`corrige` stay high per accepted key.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-low reset.
- col  in  4  keypad columns, pulled up; 0 = pressed; asynchronous to clock.
- row  out  4  row drive, one-cold, active-low.
- digit  out  4  BCD digit of the last accepted numeric key; held until the next accepted key.
- valid  out  1  high for PULSE_CYCLES on an accepted digit or confirm key.
- confirma  out  1  high together with valid when the confirm key is accepted.
- corrige  out  1  high for PULSE_CYCLES when the correction key is accepted; valid stays 0.

Behaviour:
- Reset (reset=0 at a clock edge):
  - row=4'b1110, digit=0, valid=0, confirma=0, corrige=0.
  - Synchronizer flops=4'hF, counters=0, state=SCAN.
  - Reset mid-operation aborts any debounce or pulse immediately.
- Input sync: `col` passes through a 2-flop synchronizer (sc). "Sample" = sc value on the last cycle of the SCAN_DIV dwell (tick).
- Key map, [row][col0..3]:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: `*`=corrige, 0, `#`=confirma, D
  - A–D are ignored: treated as no key.
- SCAN:
  - Row index increments on each tick, wrapping 3->0; row = ~(1<<idx).
  - At tick, if the sample has exactly one zero bit and maps to a non-ignored key: latch row/col, set deb_cnt=1, go to DEBOUNCE.
  - Zero or multiple zeros: keep scanning.
- DEBOUNCE:
  - Row frozen.
  - Each tick with a sample identical to the latched one: deb_cnt++.
  - Any mismatch: back to SCAN with row index advanced.
  - deb_cnt==DEBOUNCE_CNT: go to EMIT.
- EMIT:
  - Numeric key: digit<=code on entry; valid=1 for PULSE_CYCLES clocks.
  - Confirm key: valid=1 and confirma=1; digit unchanged.
  - Correction key: corrige=1; digit unchanged.
  - After PULSE_CYCLES clocks go to WAIT_RELEASE; strobes drop to 0 on that same edge.
- WAIT_RELEASE:
  - Row frozen.
  - Each tick where the sample is 4'hF: rel_cnt++. Any zero bit clears rel_cnt.
  - rel_cnt==DEBOUNCE_CNT: go to SCAN, row index advanced.
  - A held key therefore never repeats. A second key pressed while the first is held is ignored.
- Latency:
  - Earliest valid rise is (DEBOUNCE_CNT-1)*SCAN_DIV+1 clocks after the first qualifying tick.
  - From stable col to the first tick that can see it: up to 4*SCAN_DIV+2 clocks.
- Strobes are registered outputs, glitch-free; never more than one of valid-only, valid+confirma, corrige high at once.
- Dwell and pulse counters wrap to 0 at terminal count. Width is clog2 of the parameter, minimum 1 bit.

Optional Feature:
- Macro: TECLADO_BEEP_EN.
- Defined:
  - Adds port `beep out 1` and parameter BEEP_HALF (default 8).
  - On EMIT entry, `beep` toggles every BEEP_HALF clocks for 16*BEEP_HALF clocks, then stays 0.
  - A new EMIT during a beep restarts the beep.
  - beep=0 on reset.
- Undefined: no beep port, no beep logic; all other behaviour identical.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, PULSE_CYCLES=2):
- Reset low 2 clocks, release, no keys -> row cycles 1110,1101,1011,0111 every 4 clocks; all strobes 0.
- Hold key "5" (row1, col1 low while row=1101) for 60 clocks -> exactly one valid pulse, 2 clocks wide; digit=5; confirma=0; no repeat while held.
- Press "#" for 40 clocks -> valid=1 and confirma=1 for 2 clocks; digit keeps its previous value 5.
- Key "7" bouncing (2 good samples, then 1 released sample), then stable -> no strobe during the bounce; one valid with digit=7 after 3 consecutive good samples.
- Hold "1" and "2" simultaneously (col 1100 on row0) -> no strobe. Press "*" alone -> corrige 2 clocks, valid stays 0.
- Assert reset=0 during EMIT of "9" -> valid drops on the next edge, digit=0, row=1110; with TECLADO_BEEP_EN defined, beep=0.
